// File: rtl/rsa_word_bridge.sv
// Word-stream bridge between a host and an RSA core.
// The host writes msg, key and modulus as one frame of 3*NWORD words, least significant word
// first. The bridge presents the assembled operands to the core and waits for the result. It
// then streams the result back to the host as NWORD words, with m_last on the final word.
//
// Ports:
//   clk, rst                       clock; asynchronous active-low reset
//   s_valid/s_ready/s_data         host write stream (operand words)
//   core_valid/core_ready          operand handshake toward the RSA core
//   core_msg/core_key/core_modulus assembled operands, held stable while core_valid
//   res_valid/res_ready/res_crypto result handshake from the RSA core
//   m_valid/m_ready/m_data/m_last  host read stream (result words)
module rsa_word_bridge #(
    parameter int unsigned KEY_W  = 256,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              core_valid,
    input  logic              core_ready,
    output logic [KEY_W-1:0]  core_msg,
    output logic [KEY_W-1:0]  core_key,
    output logic [KEY_W-1:0]  core_modulus,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [KEY_W-1:0]  res_crypto,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last
);

    localparam int unsigned NWORD = KEY_W / WORD_W;
    localparam int unsigned CNT_W = $clog2(3 * NWORD);
    localparam int unsigned SEL_W = (NWORD > 1) ? $clog2(NWORD) : 1;

    localparam logic [CNT_W-1:0] LoadLast = CNT_W'(3 * NWORD - 1);
    localparam logic [CNT_W-1:0] SendLast = CNT_W'(NWORD - 1);
    localparam logic [CNT_W-1:0] NwordCnt = CNT_W'(NWORD);

    typedef enum logic [1:0] {
        StLoad,
        StIssue,
        StWait,
        StSend
    } state_e;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [NWORD-1:0][WORD_W-1:0] msg_q, key_q, mod_q, result_q;

    logic             load_fire;
    logic             res_fire;
    logic [1:0]       field_sel;
    logic [SEL_W-1:0] word_sel;

    // Status outputs decode the registered state only.
    assign s_ready    = (state_q == StLoad);
    assign core_valid = (state_q == StIssue);
    assign res_ready  = (state_q == StWait);
    assign m_valid    = (state_q == StSend);

    assign load_fire = s_valid && s_ready;
    assign res_fire  = res_valid && res_ready;

    // While loading, cnt walks msg, key and modulus in turn; while sending it indexes the result.
    assign field_sel = 2'(cnt_q / NwordCnt);
    assign word_sel  = SEL_W'(cnt_q % NwordCnt);

    assign core_msg     = msg_q;
    assign core_key     = key_q;
    assign core_modulus = mod_q;

    assign m_data = result_q[word_sel];
    assign m_last = (state_q == StSend) && (cnt_q == SendLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StLoad: begin
                if (s_valid) begin
                    if (cnt_q == LoadLast) begin
                        cnt_d   = '0;
                        state_d = StIssue;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StIssue: begin
                if (core_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (res_valid) begin
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (m_ready) begin
                    if (cnt_q == SendLast) begin
                        cnt_d   = '0;
                        state_d = StLoad;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = StLoad;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StLoad;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand and result registers keep their contents until overwritten by a new transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_q    <= '0;
            key_q    <= '0;
            mod_q    <= '0;
            result_q <= '0;
        end else begin
            if (load_fire) begin
                case (field_sel)
                    2'd0:    msg_q[word_sel] <= s_data;
                    2'd1:    key_q[word_sel] <= s_data;
                    2'd2:    mod_q[word_sel] <= s_data;
                    default: ;
                endcase
            end
            if (res_fire) begin
                result_q <= res_crypto;
            end
        end
    end

endmodule

// File: doc/rsa_word_bridge.md
RSA_WORD_BRIDGE -- requirements
Module: rsa_word_bridge

Interface
REQ-001 Parameter: KEY_W, default MOD_WIDTH from RSA_pkg (256), bit width of msg/key/modulus/crypto (KeyType).
REQ-002 Parameter: WORD_W, default 32, stream word width; KEY_W SHALL be an integer multiple of WORD_W; NWORD = KEY_W/WORD_W (8).
REQ-003 clk  input  1  clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  1  host write-stream word valid.
REQ-006 s_ready  output  1  bridge accepts host word.
REQ-007 s_data  input  WORD_W  host word.
REQ-008 core_valid  output  1  operand set valid toward RSA core.
REQ-009 core_ready  input  1  RSA core accepts operands.
REQ-010 core_msg / core_key / core_modulus  output  KEY_W each  assembled operands (KeyType).
REQ-011 res_valid  input  1  RSA core result valid.
REQ-012 res_ready  output  1  bridge accepts result.
REQ-013 res_crypto  input  KEY_W  RSA core result (KeyType).
REQ-014 m_valid  output  1  host read-stream word valid.
REQ-015 m_ready  input  1  host accepts read word.
REQ-016 m_data  output  WORD_W  result word.
REQ-017 m_last  output  1  marks final result word.

Function
REQ-018 FSM states SHALL be LOAD, ISSUE, WAIT, SEND; single word counter cnt, range 0..3*NWORD-1 (5 bits at default).
REQ-019 s_ready SHALL equal (state==LOAD); core_valid (state==ISSUE); res_ready (state==WAIT); m_valid (state==SEND); all decoded from registered state only.
REQ-020 LOAD: each cycle with s_valid&&s_ready SHALL write s_data into field cnt/NWORD (0=msg, 1=key, 2=modulus) at bits [(cnt%NWORD)*WORD_W +: WORD_W], LSW first, and increment cnt.
REQ-021 LOAD: transfer at cnt==3*NWORD-1 SHALL clear cnt to 0 and move to ISSUE next cycle; s_valid without handshake changes nothing.
REQ-022 ISSUE: core_msg/key/modulus SHALL hold stable while core_valid=1; core_valid&&core_ready moves to WAIT; core_valid SHALL NOT drop before handshake.
REQ-023 WAIT: res_valid&&res_ready SHALL latch res_crypto into result register and move to SEND with cnt=0.
REQ-024 SEND: m_data SHALL equal result[cnt*WORD_W +: WORD_W]; m_last SHALL equal (cnt==NWORD-1); m_valid&&m_ready increments cnt.
REQ-025 SEND: handshake with m_last=1 SHALL clear cnt to 0 and return to LOAD next cycle; next frame's first word accepted no earlier than that cycle.
REQ-026 m_data/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-027 Throughput: one word per cycle in LOAD and SEND with continuous valid/ready; ISSUE->WAIT minimum 1 cycle; WAIT->SEND 1 cycle after res handshake.
REQ-028 Operand registers SHALL retain prior frame contents until overwritten; result register retained until next res handshake.
REQ-029 Handshake inputs outside their state (core_ready, res_valid, m_ready, s_valid) SHALL be ignored.

Reset
REQ-030 rst low SHALL immediately force state=LOAD, cnt=0, operand and result registers 0; thus core_valid=0, res_ready=0, m_valid=0, m_last=0, m_data=0, core_* =0, s_ready=1 (no transfer taken while rst low).
REQ-031 rst asserted mid-frame (any state) SHALL discard partial frame and in-flight result; after release the first accepted word is msg word 0.

Verification
REQ-032 Full frame: msg=0x...0003, key=0x...0005, modulus=N, 24 back-to-back words, core model returns 0xF3 after 10 cycles -> core_msg=3, core_key=5 on ISSUE; 8 read words 0xF3,0,0,0,0,0,0,0 with m_last only on word 8.
REQ-033 Backpressure: s_valid toggled randomly 50%, m_ready low for 3 cycles on word 4 -> operands identical to REQ-032; m_data/m_last stable during stall; no word lost or duplicated.
REQ-034 core_ready held low 5 cycles -> core_valid stays 1, operands stable 5 cycles; state reaches WAIT only after core_ready.
REQ-035 Spurious inputs: res_valid=1 during LOAD, m_ready=1 during WAIT -> no state change, no result capture.
REQ-036 Reset after 12 words loaded -> s_ready=1, cnt=0; new 24-word frame yields fresh operands (no stale words from aborted frame).
REQ-037 Two consecutive frames -> second frame's first word accepted the cycle after first frame's m_last handshake; results correct for both.
